// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the F-D-E-M1-M2-W pipeline, with load-use hold stretching and a stall-cycle counter.
// Enables and flushes are combinational in the same cycle; state, hold counter and stall counter are registered.
module pipe_stall_ctrl #(
    parameter int LOAD_STALL_CYCLES = 2,
    parameter int CNT_W             = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             lw_stall_i,
    input  logic             branch_taken_d_i,
    input  logic             imem_wait_i,
    input  logic             dmem_wait_i,
    input  logic             mdu_busy_i,
    input  logic             cnt_clr_i,
    output logic             en_f_o,
    output logic             en_d_o,
    output logic             en_e_o,
    output logic             en_m1_o,
    output logic             en_m2_o,
    output logic             flush_d_o,
    output logic             flush_e_o,
    output logic             flush_m1_o,
    output logic             flush_w_o,
    output logic             ldhold_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic {
        RUN    = 1'b0,
        LDHOLD = 1'b1
    } state_t;

    localparam logic [2:0] HOLD_INIT = 3'(LOAD_STALL_CYCLES - 1);

    state_t           state_q, state_d;
    logic [2:0]       hcnt_q, hcnt_d;
    logic [2:0]       hcnt_dec;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_hold;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= RUN;
            hcnt_q  <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            cnt_q   <= cnt_d;
        end
    end

    // The RUN cycle that sees LW_STALL is itself the first hold cycle, so
    // LDHOLD covers the remaining LOAD_STALL_CYCLES-1 cycles.
    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        hcnt_dec = hcnt_q - 3'd1;
        if (!dmem_wait_i) begin
            case (state_q)
                RUN: begin
                    if (lw_stall_i && !mdu_busy_i && (HOLD_INIT != 3'd0)) begin
                        state_d = LDHOLD;
                        hcnt_d  = HOLD_INIT;
                    end
                end
                LDHOLD: begin
                    hcnt_d = hcnt_dec;
                    if (hcnt_dec == 3'd0) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign load_hold = (state_q == LDHOLD) || lw_stall_i;

    always_comb begin
        en_f_o     = 1'b1;
        en_d_o     = 1'b1;
        en_e_o     = 1'b1;
        en_m1_o    = 1'b1;
        en_m2_o    = 1'b1;
        flush_d_o  = 1'b0;
        flush_e_o  = 1'b0;
        flush_m1_o = 1'b0;
        flush_w_o  = 1'b0;
        if (reset_i) begin
            flush_d_o  = 1'b1;
            flush_e_o  = 1'b1;
            flush_m1_o = 1'b1;
            flush_w_o  = 1'b1;
        end else if (dmem_wait_i) begin
            en_f_o    = 1'b0;
            en_d_o    = 1'b0;
            en_e_o    = 1'b0;
            en_m1_o   = 1'b0;
            en_m2_o   = 1'b0;
            flush_w_o = 1'b1;
        end else if (mdu_busy_i) begin
            en_f_o     = 1'b0;
            en_d_o     = 1'b0;
            en_e_o     = 1'b0;
            flush_m1_o = 1'b1;
        end else if (load_hold) begin
            // A taken branch in D is ignored; it re-resolves once the hold ends.
            en_f_o    = 1'b0;
            en_d_o    = 1'b0;
            flush_e_o = 1'b1;
        end else if (imem_wait_i) begin
            en_f_o    = 1'b0;
            flush_d_o = 1'b1;
        end else if (branch_taken_d_i) begin
            flush_d_o = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (!en_d_o && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign ldhold_o    = (state_q == LDHOLD);
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (LOAD_STALL_CYCLES=2, CNT_W=4) with an expected-result queue.
module tb_pipe_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset, lw_stall, branch_taken_d, imem_wait, dmem_wait, mdu_busy, cnt_clr;
    logic       en_f, en_d, en_e, en_m1, en_m2;
    logic       flush_d, flush_e, flush_m1, flush_w, ldhold;
    logic [3:0] stall_cnt;

    typedef struct packed {
        logic [9:0] vec;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // {en_f,en_d,en_e,en_m1,en_m2, flush_d,flush_e,flush_m1,flush_w, ldhold}
    localparam logic [9:0] IDLE  = 10'b11111_0000_0;
    localparam logic [9:0] RST0  = 10'b11111_1111_0;
    localparam logic [9:0] RST1  = 10'b11111_1111_1;
    localparam logic [9:0] HOLD0 = 10'b00111_0100_0;
    localparam logic [9:0] HOLD1 = 10'b00111_0100_1;
    localparam logic [9:0] DMEM0 = 10'b00000_0001_0;
    localparam logic [9:0] DMEM1 = 10'b00000_0001_1;
    localparam logic [9:0] MDU0  = 10'b00011_0010_0;
    localparam logic [9:0] MDU1  = 10'b00011_0010_1;
    localparam logic [9:0] IMEM  = 10'b01111_1000_0;
    localparam logic [9:0] BR    = 10'b11111_1000_0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(
        .LOAD_STALL_CYCLES(2),
        .CNT_W            (4)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .lw_stall_i      (lw_stall),
        .branch_taken_d_i(branch_taken_d),
        .imem_wait_i     (imem_wait),
        .dmem_wait_i     (dmem_wait),
        .mdu_busy_i      (mdu_busy),
        .cnt_clr_i       (cnt_clr),
        .en_f_o          (en_f),
        .en_d_o          (en_d),
        .en_e_o          (en_e),
        .en_m1_o         (en_m1),
        .en_m2_o         (en_m2),
        .flush_d_o       (flush_d),
        .flush_e_o       (flush_e),
        .flush_m1_o      (flush_m1),
        .flush_w_o       (flush_w),
        .ldhold_o        (ldhold),
        .stall_cnt_o     (stall_cnt)
    );

    wire [9:0] obs = {en_f, en_d, en_e, en_m1, en_m2, flush_d, flush_e, flush_m1, flush_w, ldhold};

    // One cycle: drive inputs after the edge, queue the expectation, compare at the falling edge.
    task automatic step(input string tag, input logic rst, input logic lw, input logic br,
                        input logic im, input logic dm, input logic mdu, input logic clr,
                        input logic [9:0] ev, input logic [3:0] ec);
        exp_t e;
        exp_t got;
        @(posedge clk);
        #1;
        reset          = rst;
        lw_stall       = lw;
        branch_taken_d = br;
        imem_wait      = im;
        dmem_wait      = dm;
        mdu_busy       = mdu;
        cnt_clr        = clr;
        e.vec = ev;
        e.cnt = ec;
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        checks++;
        assert (obs === got.vec) else begin
            errors++;
            $error("FAIL %s outputs: got %b want %b", tag, obs, got.vec);
        end
        checks++;
        assert (stall_cnt === got.cnt) else begin
            errors++;
            $error("FAIL %s stall_cnt: got %0d want %0d", tag, stall_cnt, got.cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; lw_stall = 1'b0; branch_taken_d = 1'b0; imem_wait = 1'b0;
        dmem_wait = 1'b0; mdu_busy = 1'b0; cnt_clr = 1'b0;

        //   tag            rst lw br im dm md clr  outputs cnt
        step("rst",          1, 0, 0, 0, 0, 0, 0, RST0,  4'd0);
        step("idle0",        0, 0, 0, 0, 0, 0, 0, IDLE,  4'd0);
        step("idle1",        0, 0, 0, 0, 0, 0, 0, IDLE,  4'd0);
        step("lw_t0",        0, 1, 0, 0, 0, 0, 0, HOLD0, 4'd0);
        step("lw_t1",        0, 0, 0, 0, 0, 0, 0, HOLD1, 4'd1);
        step("lw_t2",        0, 0, 0, 0, 0, 0, 0, IDLE,  4'd2);
        step("lwbr_t0",      0, 1, 1, 0, 0, 0, 0, HOLD0, 4'd2);
        step("lwbr_t1",      0, 0, 1, 0, 0, 0, 0, HOLD1, 4'd3);
        step("br_alone",     0, 0, 1, 0, 0, 0, 0, BR,    4'd4);
        step("clr",          0, 0, 0, 0, 0, 0, 1, IDLE,  4'd4);
        step("after_clr",    0, 0, 0, 0, 0, 0, 0, IDLE,  4'd0);
        step("lwdm_t0",      0, 1, 0, 0, 0, 0, 0, HOLD0, 4'd0);
        step("lwdm_t1",      0, 0, 0, 0, 1, 0, 0, DMEM1, 4'd1);
        step("lwdm_t2",      0, 0, 0, 0, 0, 0, 0, HOLD1, 4'd2);
        step("lwdm_t3",      0, 0, 0, 0, 0, 0, 0, IDLE,  4'd3);
        for (int i = 0; i < 4; i++) begin
            step("mdu",      0, 0, 0, 0, 0, 1, 0, MDU0,  4'(3 + i));
        end
        step("mdu_done",     0, 0, 0, 0, 0, 0, 0, IDLE,  4'd7);
        step("imem",         0, 0, 0, 1, 0, 0, 0, IMEM,  4'd7);
        step("imem_br",      0, 0, 1, 1, 0, 0, 0, IMEM,  4'd7);
        step("lw_imem",      0, 1, 0, 1, 0, 0, 0, HOLD0, 4'd7);
        step("lw_in_hold",   0, 1, 0, 0, 0, 0, 0, HOLD1, 4'd8);
        step("no_restart",   0, 0, 0, 0, 0, 0, 0, IDLE,  4'd9);
        step("lw_mdu_run",   0, 1, 0, 0, 0, 1, 0, MDU0,  4'd9);
        step("no_entry",     0, 0, 0, 0, 0, 0, 0, IDLE,  4'd10);
        step("lw_t0b",       0, 1, 0, 0, 0, 0, 0, HOLD0, 4'd10);
        step("mdu_in_hold",  0, 0, 0, 0, 0, 1, 0, MDU1,  4'd11);
        step("hold_over",    0, 0, 0, 0, 0, 0, 1, IDLE,  4'd12);
        for (int i = 0; i < 20; i++) begin
            step("sat",      0, 0, 0, 0, 1, 0, 0, DMEM0, (i > 15) ? 4'd15 : 4'(i));
        end
        step("clr_stall",    0, 0, 0, 0, 1, 0, 1, DMEM0, 4'd15);
        step("clr_wins",     0, 0, 0, 0, 0, 0, 0, IDLE,  4'd0);
        step("lw_t0c",       0, 1, 0, 0, 0, 0, 0, HOLD0, 4'd0);
        step("rst_in_hold",  1, 0, 0, 0, 0, 0, 0, RST1,  4'd1);
        step("post_rst",     0, 0, 0, 0, 0, 0, 0, IDLE,  4'd0);
        step("lw_t0d",       0, 1, 0, 0, 0, 0, 0, HOLD0, 4'd0);
        step("lw_t1d",       0, 0, 0, 0, 1, 0, 0, DMEM1, 4'd1);
        step("rst_in_wait",  1, 0, 0, 0, 1, 0, 0, RST1,  4'd2);
        step("post_rst2",    0, 0, 0, 0, 0, 0, 0, IDLE,  4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Pipeline stall/flush controller for the six-stage core (F, D, E, M1, M2, W). It consumes the hazard unit's load-use stall request plus the memory, multiplier/divider and branch events, and drives per-stage register enables and bubble-insert flushes. It also stretches a single-cycle load-use request into the full load-to-use gap, because loaded data is only forwardable from W. A saturating counter records stalled cycles for performance measurement.

## Interface
- LOAD_STALL_CYCLES, 2: D-hold cycles per load-use stall (1..7)
- CNT_W, 16: width of stall-cycle counter
- CLK  in  1  core clock
- RESET  in  1  synchronous, active-high reset
- LW_STALL  in  1  load-use request from hazard unit (load in E, dependent op in D)
- BRANCH_TAKEN_D  in  1  branch/jump in D resolved taken
- IMEM_WAIT  in  1  instruction fetch not ready this cycle
- DMEM_WAIT  in  1  data memory not ready for M1/M2 access
- MDU_BUSY  in  1  multi-cycle MUL/DIV in E not finished
- CNT_CLR  in  1  clear stall counter
- EN_F, EN_D, EN_E, EN_M1, EN_M2  out  1 each  stage register load enable
- FLUSH_D, FLUSH_E, FLUSH_M1, FLUSH_W  out  1 each  load a bubble into that stage register
- LDHOLD  out  1  FSM in LDHOLD state
- STALL_CNT  out  CNT_W  saturating count of cycles with EN_D=0

## Operation
- FSM states: RUN, LDHOLD. Down-counter HCNT (3 bits).
- RUN -> LDHOLD when LW_STALL=1 and DMEM_WAIT=0 and MDU_BUSY=0; HCNT <= LOAD_STALL_CYCLES-1.
- In LDHOLD, HCNT decrements each cycle DMEM_WAIT=0. LDHOLD -> RUN on the cycle after HCNT reaches 0.
- While LW_STALL=1 in RUN and no higher-priority condition is active, the first hold cycle is that same cycle.
- LOAD_STALL_CYCLES=1 gives a single-cycle hold with no LDHOLD visit.
- Priority: DMEM_WAIT, then MDU_BUSY, then load hold (LW_STALL in RUN, or LDHOLD), then IMEM_WAIT, then BRANCH_TAKEN_D.
  - DMEM_WAIT: EN_F..EN_M2=0; FLUSH_W=1; all other flushes 0; FSM and HCNT frozen.
  - MDU_BUSY: EN_F, EN_D, EN_E=0; EN_M1, EN_M2=1; FLUSH_M1=1.
  - Load hold: EN_F, EN_D=0; EN_E..EN_M2=1; FLUSH_E=1; BRANCH_TAKEN_D ignored (the D instruction re-resolves after the hold).
  - IMEM_WAIT: EN_F=0; the other enables 1; FLUSH_D=1, unless a taken branch is present, in which case FLUSH_D=1 anyway.
  - BRANCH_TAKEN_D alone: all enables 1; FLUSH_D=1 (kills the delay-slot-free fetch).
  - None of the above: all enables 1, all flushes 0.
- A flush asserted with its stage enable 0 is illegal. The block never produces that combination.
- STALL_CNT increments when EN_D=0 and saturates at 2^CNT_W-1. CNT_CLR takes precedence over increment.
- Width rules: HCNT compares against 0 only. LOAD_STALL_CYCLES outside 1..7 is unsupported.

## Timing
- Enables and flushes are combinational from the inputs and registered state, valid within the same cycle. There is no added latency.
- State, HCNT and STALL_CNT update on the CLK rising edge.
- Reset, while RESET=1:
  - All EN_* = 1 and all FLUSH_* = 1, so the pipeline fills with bubbles.
  - After the edge: state RUN, HCNT=0, STALL_CNT=0, LDHOLD=0.
- Reset asserted mid-LDHOLD or mid-wait aborts the hold. The first cycle after reset behaves as RUN with inputs applied.
- LW_STALL while already in LDHOLD does not restart HCNT.
- A DMEM_WAIT cycle inside LDHOLD extends the hold by one cycle: hold cycles counted = LOAD_STALL_CYCLES + number of DMEM_WAIT cycles.
- MDU_BUSY while in LDHOLD: the MDU rule drives the outputs; HCNT still decrements.

## Test plan
- Reset, then idle -> during RESET all enables and flushes are 1. After release, enables are 1, flushes 0, STALL_CNT=0.
- LW_STALL pulse for 1 cycle at t0, LOAD_STALL_CYCLES=2 -> EN_D=0 and FLUSH_E=1 at t0 and t1, RUN at t2, STALL_CNT=2.
- Same as the previous case, with DMEM_WAIT=1 at t1 -> at t1 EN_F..EN_M2=0 and FLUSH_W=1. Hold ends after t2. EN_D=0 for 3 cycles. STALL_CNT=3.
- BRANCH_TAKEN_D=1 together with LW_STALL=1 -> FLUSH_D=0 and FLUSH_E=1. BRANCH_TAKEN_D=1 alone -> FLUSH_D=1 with all enables 1.
- MDU_BUSY held 4 cycles -> EN_F, EN_D, EN_E=0 and FLUSH_M1=1 for 4 cycles. STALL_CNT +4.
- CNT_W=4 with 20 consecutive stall cycles -> STALL_CNT saturates at 15. CNT_CLR=1 together with a stall -> 0 next cycle. RESET asserted in LDHOLD -> LDHOLD=0 after the edge.
